scan_chain_ctrl: RTL
====================

// Module: scan_chain_ctrl
// PURPOSE
//  Drives and unloads a chain of scan-mux flip-flops (D0 functional, D1 scan-in, SD select, SP enable).
//  Per request: optionally captures functional data into the chain, then shifts CHAIN_LEN bits out while
//  shifting a new pattern in. Sits beside test/debug logic; one controller per chain.
// PARAMETERS
//  CHAIN_LEN    16   number of flops in the chain, 2..256
//  CAPTURE_EN   1    1: one capture cycle precedes shifting; 0: shift only
//  CNT_W        8    shift counter width, must satisfy 2**CNT_W > CHAIN_LEN
// PORTS
//  CK        in   1          rising-edge clock, shared with the chain
//  RSTN      in   1          asynchronous active-low reset
//  START     in   1          request pulse, accepted only in IDLE
//  STALL     in   1          pause shifting while high
//  LD_DATA   in   CHAIN_LEN  pattern to load, sampled on START acceptance
//  SO        in   1          chain tail Q (flop CHAIN_LEN-1)
//  SD        out  1          scan select to every chain flop (1 = take D1)
//  SP        out  1          clock enable to every chain flop
//  SI        out  1          scan data to D1 of chain head (flop 0)
//  CAP_DATA  out  CHAIN_LEN  unloaded chain contents
//  BUSY      out  1          high from START acceptance until DONE cycle inclusive
//  DONE      out  1          one-cycle pulse, CAP_DATA valid from this cycle
// BEHAVIOUR
//  Reset: async on RSTN low, state IDLE, SD=0 SP=0 SI=0 BUSY=0 DONE=0 CAP_DATA=0, counter=0.
//   Deassertion is synchronous to CK; no chain activity until a START is accepted.
//  All outputs registered. FSM: IDLE -> CAPTURE -> SHIFT -> FINISH -> IDLE.
//  IDLE: SD=0 SP=0. START=1 at edge: latch LD_DATA into shadow, BUSY=1; next state CAPTURE
//   (CAPTURE_EN=1) or SHIFT (CAPTURE_EN=0).
//  CAPTURE: exactly one cycle, SD=0 SP=1; chain loads D0. STALL ignored here.
//  SHIFT: SD=1; SP = ~STALL. Counter k = 0..CHAIN_LEN-1 counts enabled cycles only.
//   During cycle k: SI = shadow[k]. At the edge ending an enabled cycle: CAP_DATA[k] <= SO, k++.
//   After CHAIN_LEN enabled cycles -> FINISH. STALL cycles: SP=0, k, SI, CAP_DATA hold.
//  Bit mapping: CAP_DATA[i] = pre-shift value of flop CHAIN_LEN-1-i;
//   LD_DATA[i] ends in flop CHAIN_LEN-1-i after the shift.
//  FINISH: one cycle, SD=0 SP=0 DONE=1 BUSY=1; next IDLE (BUSY=0, DONE=0).
//  START while BUSY: ignored, no queuing. START in the FINISH cycle: ignored.
//  START in the IDLE cycle right after FINISH: accepted.
//  SD and SP never both change from an enabled shift into capture within one cycle;
//   SD=0 whenever SP=0 outside SHIFT.
//  CAP_DATA holds its value between operations; it is overwritten bit by bit during SHIFT
//   (valid only at DONE).
//  Reset mid-operation: immediate abort to reset values; a partially shifted chain is left as is.
// TESTING
//  1 Reset: RSTN=0 mid-SHIFT -> same cycle SD=0 SP=0 BUSY=0 CAP_DATA=0; no DONE afterwards.
//  2 CHAIN_LEN=16, chain D0=16'hA5C3, LD_DATA=16'h1234, START -> 1 capture cycle, 16 shifts, DONE at
//    cycle 18 after START; CAP_DATA=16'hA5C3 in flop order, chain then holds 16'h1234 in flop order.
//  3 STALL high 3 cycles at k=5 -> SP=0 for those 3 cycles, DONE delayed exactly 3 cycles, data unchanged.
//  4 START pulsed during SHIFT and in the FINISH cycle -> ignored; exactly one DONE.
//  5 CAPTURE_EN=0 -> first cycle after START is a shift (SD=1); DONE 17 cycles after START.
//  6 Back-to-back: START the cycle after DONE falls -> accepted; second unload returns first LD_DATA.

Source files
------------

// File: rtl/scan_chain_ctrl.sv
// Scan chain controller: optional capture cycle, then CHAIN_LEN shift cycles that
// unload the chain into CAP_DATA while loading a new pattern through SI.
module scan_chain_ctrl #(
  parameter int unsigned CHAIN_LEN  = 16,
  parameter int unsigned CAPTURE_EN = 1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                 CK,
  input  logic                 RSTN,
  input  logic                 START,
  input  logic                 STALL,
  input  logic [CHAIN_LEN-1:0] LD_DATA,
  input  logic                 SO,
  output logic                 SD,
  output logic                 SP,
  output logic                 SI,
  output logic [CHAIN_LEN-1:0] CAP_DATA,
  output logic                 BUSY,
  output logic                 DONE
);

  typedef enum logic [1:0] {IDLE, CAPTURE, SHIFT, FINISH} state_t;

  localparam logic [CHAIN_LEN-1:0] ONE  = {{(CHAIN_LEN-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]     LAST = CNT_W'(CHAIN_LEN - 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0]   shadow_q, shadow_d;
  logic [CHAIN_LEN-1:0]   cap_q, cap_d;
  logic                   sd_q, sd_d;
  logic                   sp_q, sp_d;
  logic                   si_q, si_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    cap_d    = cap_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          shadow_d = LD_DATA;
          cnt_d    = '0;
          state_d  = (CAPTURE_EN != 0) ? CAPTURE : SHIFT;
        end
      end
      CAPTURE: state_d = SHIFT;
      SHIFT: begin
        // sp_q is high exactly in the enabled (non-stalled) shift cycles
        if (sp_q) begin
          cap_d = (cap_q & ~(ONE << cnt_q)) |
                  ({{(CHAIN_LEN-1){1'b0}}, SO} << cnt_q);
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = FINISH;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    sd_d   = (state_d == SHIFT);
    sp_d   = (state_d == CAPTURE) || ((state_d == SHIFT) && !STALL);
    si_d   = (state_d == SHIFT) && |(shadow_d & (ONE << cnt_d));
    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      cap_q    <= '0;
      sd_q     <= 1'b0;
      sp_q     <= 1'b0;
      si_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      cap_q    <= cap_d;
      sd_q     <= sd_d;
      sp_q     <= sp_d;
      si_q     <= si_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign SD       = sd_q;
  assign SP       = sp_q;
  assign SI       = si_q;
  assign CAP_DATA = cap_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule
